call_stack: RTL and testbench
=============================

CALL_STACK -- requirements
Module: call_stack

Parameters
REQ-001 SHALL provide WIDTH, default 12, bit width of each stored return address.
REQ-002 SHALL provide DEPTH, default 8, number of entries; legal values are powers of two, at least 2.
REQ-003 SHALL provide OVF_WRAP, default 0: 0 = reject push when full; 1 = overwrite oldest entry when full.

Interface
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 cen  input  1  clock enable; low holds all state and ignores every other input except rst.
REQ-007 push_i  input  1  push pc_i onto the stack.
REQ-008 pop_i  input  1  remove the top entry.
REQ-009 pc_i  input  WIDTH  address to push.
REQ-010 err_clr_i  input  1  clear the sticky error flags.
REQ-011 pc_o  output  WIDTH  registered top-of-stack value.
REQ-012 count_o  output  $clog2(DEPTH+1)  number of valid entries, range 0..DEPTH.
REQ-013 empty_o / full_o  output  1 each  count_o==0 / count_o==DEPTH, combinational from count.
REQ-014 ovf_o / unf_o  output  1 each  sticky overflow / underflow flags.

Function (all operations require cen=1 and rst=1 at the rising edge)
REQ-015 Push only, not full: SHALL write pc_i at the top slot, increment count, and drive pc_o=pc_i on the next cycle.
REQ-016 Pop only, not empty: SHALL decrement count; next cycle pc_o SHALL equal the new top entry, or 0 if the stack is now empty.
REQ-017 Push and pop together, not empty: SHALL replace the top entry with pc_i with count unchanged; next cycle pc_o=pc_i.
REQ-018 Push and pop together, empty: SHALL behave as a plain push, with no error raised.
REQ-019 Push only, full, OVF_WRAP=0: SHALL leave stack contents, count and pc_o unchanged, and set ovf_o.
REQ-020 Push only, full, OVF_WRAP=1: SHALL discard the oldest entry, store pc_i as the top, keep count=DEPTH, set pc_o=pc_i, and set ovf_o.
REQ-021 Pop only, empty: SHALL leave all state unchanged, keep pc_o=0, and set unf_o.
REQ-022 No push and no pop: SHALL hold all state; pc_o SHALL continue to reflect the current top entry.
REQ-023 Top-pointer arithmetic SHALL be modulo DEPTH; a wrap-around SHALL NOT alter count beyond the 0..DEPTH range.
REQ-024 err_clr_i SHALL clear ovf_o and unf_o on the next edge; if a new error occurs in the same cycle, the set SHALL take priority over the clear.
REQ-025 Latency from any operation to its pc_o or count_o effect SHALL be exactly 1 cycle; no combinational path from push_i, pop_i or pc_i to pc_o.
REQ-026 cen=0 SHALL freeze count, contents, pc_o and flags regardless of push_i, pop_i and err_clr_i.

Reset
REQ-027 rst=0 at a rising edge SHALL force count_o=0, pc_o=0, ovf_o=0 and unf_o=0, independent of cen.
REQ-028 Reset SHALL take priority over any concurrent push, pop or clear; storage contents are don't-care after reset and SHALL NOT be visible on pc_o.
REQ-029 Reset asserted mid-sequence SHALL discard all pending stack state; the first push after reset SHALL behave as a push to an empty stack.

Verification (WIDTH=12, DEPTH=8)
REQ-030 Push 0x100, 0x200, 0x300, then three pops -> pc_o sequence 0x100, 0x200, 0x300, 0x200, 0x100, 0x000; count sequence 1,2,3,2,1,0.
REQ-031 OVF_WRAP=0: push 0x001..0x008, then push 0x009 -> full_o=1, count=8, pc_o=0x008, ovf_o=1; eight pops then return 0x008 down to 0x001.
REQ-032 OVF_WRAP=1: push 0x001..0x009 -> count=8, ovf_o=1, pc_o=0x009; eight pops then return 0x009 down to 0x002, followed by empty_o=1.
REQ-033 Pop with the stack empty -> unf_o=1, pc_o=0, count=0; then err_clr_i pulse -> unf_o=0 the next cycle; err_clr_i together with another empty pop -> unf_o stays 1.
REQ-034 Push 0x0AA, then push+pop with pc_i=0x0BB -> count=1, pc_o=0x0BB; then pop -> empty_o=1.
REQ-035 Push 0x123 with cen=0 -> no change; then push 0x456, 0x789 and assert rst=0 for 1 cycle -> count=0, pc_o=0, flags=0; then push 0x111 -> count=1, pc_o=0x111.

Source files
------------

// File: rtl/call_stack_if.sv
// Call-stack port bundle: push/pop requests toward the stack (master side)
// and the registered stack status back (slave side is the stack itself).
interface call_stack_if #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             cen;
  logic             push_i;
  logic             pop_i;
  logic [WIDTH-1:0] pc_i;
  logic             err_clr_i;
  logic [WIDTH-1:0] pc_o;
  logic [CW-1:0]    count_o;
  logic             empty_o;
  logic             full_o;
  logic             ovf_o;
  logic             unf_o;

  modport master (
    output cen, push_i, pop_i, pc_i, err_clr_i,
    input  pc_o, count_o, empty_o, full_o, ovf_o, unf_o
  );

  modport slave (
    input  cen, push_i, pop_i, pc_i, err_clr_i,
    output pc_o, count_o, empty_o, full_o, ovf_o, unf_o
  );
endinterface

// File: rtl/call_stack.sv
// Return-address stack with registered top-of-stack output, sticky
// overflow/underflow flags and optional overwrite-oldest on overflow.
module call_stack #(
  parameter int WIDTH    = 12,
  parameter int DEPTH    = 8,
  parameter int OVF_WRAP = 0
) (
  input logic         clk,
  input logic         rst,
  call_stack_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    sp, sp_n, wr_idx;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] pc_q, pc_n;
  logic             ovf_q, unf_q, ovf_n, unf_n;
  logic             ovf_set, unf_set, wr_en;
  logic             empty, full;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

  // sp addresses the current top entry; storage is circular, so the slot
  // above the top of a full stack is the oldest entry (overwritten on wrap).
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = sp + AW'(1);
    sp_n    = sp;
    cnt_n   = cnt;
    pc_n    = pc_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (bus.push_i && bus.pop_i && !empty) begin
      wr_en  = 1'b1;
      wr_idx = sp;
      pc_n   = bus.pc_i;
    end else if (bus.push_i) begin
      if (!full) begin
        wr_en = 1'b1;
        sp_n  = sp + AW'(1);
        cnt_n = cnt + CW'(1);
        pc_n  = bus.pc_i;
      end else begin
        ovf_set = 1'b1;
        if (OVF_WRAP != 0) begin
          wr_en = 1'b1;
          sp_n  = sp + AW'(1);
          pc_n  = bus.pc_i;
        end
      end
    end else if (bus.pop_i) begin
      if (empty) begin
        unf_set = 1'b1;
      end else begin
        sp_n  = sp - AW'(1);
        cnt_n = cnt - CW'(1);
        pc_n  = (cnt == CW'(1)) ? '0 : mem[sp - AW'(1)];
      end
    end
    ovf_n = ovf_set | (ovf_q & ~bus.err_clr_i);
    unf_n = unf_set | (unf_q & ~bus.err_clr_i);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sp    <= '0;
      cnt   <= '0;
      pc_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (bus.cen) begin
      sp    <= sp_n;
      cnt   <= cnt_n;
      pc_q  <= pc_n;
      ovf_q <= ovf_n;
      unf_q <= unf_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && bus.cen && wr_en) begin
      mem[wr_idx] <= bus.pc_i;
    end
  end

  assign bus.pc_o    = pc_q;
  assign bus.count_o = cnt;
  assign bus.empty_o = empty;
  assign bus.full_o  = full;
  assign bus.ovf_o   = ovf_q;
  assign bus.unf_o   = unf_q;
endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack: reject-on-full and wrap-on-full instances share one
// stimulus stream; an array-based reference stack feeds per-instance queues.
module tb_call_stack;
  typedef struct packed {
    logic [11:0] pc;
    logic [3:0]  cnt;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  exp_t sb0[$];
  exp_t sb1[$];

  logic [11:0] mstk [2][8];
  int          mcnt [2];
  logic [11:0] mpc  [2];
  logic        movf [2];
  logic        munf [2];

  always #5 clk = ~clk;

  call_stack_if #(.WIDTH(12), .DEPTH(8)) b0 ();
  call_stack_if #(.WIDTH(12), .DEPTH(8)) b1 ();

  call_stack #(.WIDTH(12), .DEPTH(8), .OVF_WRAP(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  call_stack #(.WIDTH(12), .DEPTH(8), .OVF_WRAP(1)) u1 (.clk(clk), .rst(rst), .bus(b1));

  function automatic void model_step(int w, logic p, logic q, logic [11:0] pc,
                                     logic clr, logic ce, logic rv);
    logic os, us;
    os = 1'b0;
    us = 1'b0;
    if (!rv) begin
      mcnt[w] = 0; mpc[w] = '0; movf[w] = 1'b0; munf[w] = 1'b0;
    end else if (ce) begin
      if (p && q && mcnt[w] > 0) begin
        mstk[w][mcnt[w]-1] = pc;
        mpc[w] = pc;
      end else if (p) begin
        if (mcnt[w] < 8) begin
          mstk[w][mcnt[w]] = pc;
          mcnt[w]++;
          mpc[w] = pc;
        end else begin
          os = 1'b1;
          if (w == 1) begin
            for (int i = 0; i < 7; i++) mstk[w][i] = mstk[w][i+1];
            mstk[w][7] = pc;
            mpc[w] = pc;
          end
        end
      end else if (q) begin
        if (mcnt[w] == 0) us = 1'b1;
        else begin
          mcnt[w]--;
          mpc[w] = (mcnt[w] == 0) ? 12'h000 : mstk[w][mcnt[w]-1];
        end
      end
      movf[w] = os | (movf[w] & ~clr);
      munf[w] = us | (munf[w] & ~clr);
    end
  endfunction

  function automatic exp_t exp_of(int w);
    return {mpc[w], 4'(mcnt[w]), mcnt[w] == 0, mcnt[w] == 8, movf[w], munf[w]};
  endfunction

  function automatic exp_t act(int w);
    if (w == 0) return {b0.pc_o, b0.count_o, b0.empty_o, b0.full_o, b0.ovf_o, b0.unf_o};
    return {b1.pc_o, b1.count_o, b1.empty_o, b1.full_o, b1.ovf_o, b1.unf_o};
  endfunction

  function automatic string fmt(exp_t e);
    return $sformatf("pc=%h cnt=%0d empty=%b full=%b ovf=%b unf=%b",
                     e.pc, e.cnt, e.empty, e.full, e.ovf, e.unf);
  endfunction

  task automatic cyc(input logic p, input logic q, input logic [11:0] pc,
                     input logic clr, input logic ce, input logic rv);
    rst = rv;
    b0.push_i = p; b0.pop_i = q; b0.pc_i = pc; b0.err_clr_i = clr; b0.cen = ce;
    b1.push_i = p; b1.pop_i = q; b1.pc_i = pc; b1.err_clr_i = clr; b1.cen = ce;
    model_step(0, p, q, pc, clr, ce, rv);
    model_step(1, p, q, pc, clr, ce, rv);
    sb0.push_back(exp_of(0));
    sb1.push_back(exp_of(1));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e0, e1;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) cyc(1'b1, 1'b1, 12'hFFF, 1'b1, 1'b0, 1'b0);
      else        cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
      e0 = sb0.pop_front(); e1 = sb1.pop_front();
      checks += 3;
      if (act(0) !== e0) begin errors++; $display("FAIL reset[%0d] dut0 got %s exp %s", i, fmt(act(0)), fmt(e0)); end
      if (act(1) !== e1) begin errors++; $display("FAIL reset[%0d] dut1 got %s exp %s", i, fmt(act(1)), fmt(e1)); end
      if ({b0.pc_o, b0.count_o, b0.ovf_o, b0.unf_o} !== 18'd0) begin
        errors++; $display("FAIL reset_zero[%0d] got %s exp all zero", i, fmt(act(0)));
      end
    end
  endtask

  task automatic test_lifo();
    logic [11:0] pcs  [6] = '{12'h100, 12'h200, 12'h300, 12'h000, 12'h000, 12'h000};
    logic [11:0] epc  [6] = '{12'h100, 12'h200, 12'h300, 12'h200, 12'h100, 12'h000};
    logic [3:0]  ecnt [6] = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0};
    exp_t e0, e1;
    cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1);
    void'(sb0.pop_front()); void'(sb1.pop_front());
    for (int i = 0; i < 6; i++) begin
      cyc(i < 3, i >= 3, pcs[i], 1'b0, 1'b1, 1'b1);
      e0 = sb0.pop_front(); e1 = sb1.pop_front();
      checks += 3;
      if (act(0) !== e0) begin errors++; $display("FAIL lifo[%0d] dut0 got %s exp %s", i, fmt(act(0)), fmt(e0)); end
      if (act(1) !== e1) begin errors++; $display("FAIL lifo[%0d] dut1 got %s exp %s", i, fmt(act(1)), fmt(e1)); end
      if (b0.pc_o !== epc[i] || b0.count_o !== ecnt[i]) begin
        errors++; $display("FAIL lifo_seq[%0d] got pc=%h cnt=%0d exp pc=%h cnt=%0d", i, b0.pc_o, b0.count_o, epc[i], ecnt[i]);
      end
    end
  endtask

  task automatic test_overflow();
    exp_t e0, e1;
    for (int i = 1; i <= 19; i++) begin
      if (i <= 9)       cyc(1'b1, 1'b0, 12'(i), 1'b0, 1'b1, 1'b1);
      else if (i <= 17) cyc(1'b0, 1'b1, 12'h000, 1'b0, 1'b1, 1'b1);
      else if (i == 18) cyc(1'b0, 1'b1, 12'h000, 1'b0, 1'b1, 1'b1);
      else              cyc(1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1);
      e0 = sb0.pop_front(); e1 = sb1.pop_front();
      checks += 2;
      if (act(0) !== e0) begin errors++; $display("FAIL overflow[%0d] dut0 got %s exp %s", i, fmt(act(0)), fmt(e0)); end
      if (act(1) !== e1) begin errors++; $display("FAIL overflow[%0d] dut1 got %s exp %s", i, fmt(act(1)), fmt(e1)); end
      if (i == 9) begin
        checks += 2;
        if ({b0.full_o, b0.count_o, b0.pc_o, b0.ovf_o} !== {1'b1, 4'd8, 12'h008, 1'b1}) begin
          errors++; $display("FAIL ovf_reject got %s exp pc=008 cnt=8 full=1 ovf=1", fmt(act(0)));
        end
        if ({b1.count_o, b1.pc_o, b1.ovf_o} !== {4'd8, 12'h009, 1'b1}) begin
          errors++; $display("FAIL ovf_wrap got %s exp pc=009 cnt=8 ovf=1", fmt(act(1)));
        end
      end
      if (i == 17) begin
        checks++;
        if ({b0.empty_o, b1.empty_o} !== 2'b11) begin
          errors++; $display("FAIL ovf_drain got empty0=%b empty1=%b exp 1 1", b0.empty_o, b1.empty_o);
        end
      end
    end
  endtask

  task automatic test_underflow();
    logic p   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic clr [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic eu  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_t e0, e1;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, p[i], 12'h000, clr[i], 1'b1, 1'b1);
      e0 = sb0.pop_front(); e1 = sb1.pop_front();
      checks += 3;
      if (act(0) !== e0) begin errors++; $display("FAIL underflow[%0d] dut0 got %s exp %s", i, fmt(act(0)), fmt(e0)); end
      if (act(1) !== e1) begin errors++; $display("FAIL underflow[%0d] dut1 got %s exp %s", i, fmt(act(1)), fmt(e1)); end
      if ({b0.unf_o, b0.pc_o, b0.count_o} !== {eu[i], 12'h000, 4'd0}) begin
        errors++; $display("FAIL unf_flag[%0d] got %s exp unf=%b pc=000 cnt=0", i, fmt(act(0)), eu[i]);
      end
    end
  endtask

  task automatic test_replace();
    logic        p   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        q   [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [11:0] pcs [5] = '{12'h055, 12'h000, 12'h0AA, 12'h0BB, 12'h000};
    exp_t e0, e1;
    for (int i = 0; i < 5; i++) begin
      cyc(p[i], q[i], pcs[i], 1'b0, 1'b1, 1'b1);
      e0 = sb0.pop_front(); e1 = sb1.pop_front();
      checks += 2;
      if (act(0) !== e0) begin errors++; $display("FAIL replace[%0d] dut0 got %s exp %s", i, fmt(act(0)), fmt(e0)); end
      if (act(1) !== e1) begin errors++; $display("FAIL replace[%0d] dut1 got %s exp %s", i, fmt(act(1)), fmt(e1)); end
      if (i == 0 || i == 3) begin
        checks++;
        if ({b0.count_o, b0.pc_o, b0.unf_o} !== {4'd1, pcs[i], 1'b0}) begin
          errors++; $display("FAIL replace_top[%0d] got %s exp cnt=1 pc=%h unf=0", i, fmt(act(0)), pcs[i]);
        end
      end
    end
  endtask

  task automatic test_cen_reset();
    logic        p   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        q   [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [11:0] pcs [7] = '{12'h123, 12'h000, 12'h000, 12'h456, 12'h789, 12'h777, 12'h111};
    logic        clr [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        ce  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        rv  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_t e0, e1;
    for (int i = 0; i < 7; i++) begin
      cyc(p[i], q[i], pcs[i], clr[i], ce[i], rv[i]);
      e0 = sb0.pop_front(); e1 = sb1.pop_front();
      checks += 2;
      if (act(0) !== e0) begin errors++; $display("FAIL cen_reset[%0d] dut0 got %s exp %s", i, fmt(act(0)), fmt(e0)); end
      if (act(1) !== e1) begin errors++; $display("FAIL cen_reset[%0d] dut1 got %s exp %s", i, fmt(act(1)), fmt(e1)); end
      if (i == 2 || i == 5 || i == 6) begin
        checks++;
        if ({b0.count_o, b0.pc_o, b0.unf_o} !== {(i == 6) ? 4'd1 : 4'd0, (i == 6) ? 12'h111 : 12'h000, i == 2}) begin
          errors++; $display("FAIL cen_reset_spot[%0d] got %s", i, fmt(act(0)));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e0, e1;
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom),
          $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 63) != 0);
      e0 = sb0.pop_front(); e1 = sb1.pop_front();
      checks += 2;
      if (act(0) !== e0) begin errors++; $display("FAIL random[%0d] dut0 got %s exp %s", i, fmt(act(0)), fmt(e0)); end
      if (act(1) !== e1) begin errors++; $display("FAIL random[%0d] dut1 got %s exp %s", i, fmt(act(1)), fmt(e1)); end
    end
  endtask

  initial begin
    b0.cen = 1'b0; b0.push_i = 1'b0; b0.pop_i = 1'b0; b0.pc_i = '0; b0.err_clr_i = 1'b0;
    b1.cen = 1'b0; b1.push_i = 1'b0; b1.pop_i = 1'b0; b1.pc_i = '0; b1.err_clr_i = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_lifo();
    test_overflow();
    test_underflow();
    test_replace();
    test_cen_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
